fixed_to_float_norm_v: RTL and testbench



---
 rtl/fixed_to_float_norm_v.sv | 147 ++++++++++++++
 tb/tb_fixed_to_float_norm_v.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_to_float_norm_v.sv
// Signed fixed-point (FRAC_BITS fractional bits) to IEEE-754 single converter.
// Define FIXED_TO_FLOAT_ROUND_NEAREST_EN for round-to-nearest-even packing; the default build truncates.
//
// state | meaning
// IDLE  | waiting for BEGIN_FSM_FX, operand captured on the begin edge
// CHECK | classify magnitude: zero, already normalised, or needs shifting
// NORM  | shift magnitude left one bit per cycle until bit31 is set
// PACK  | assemble sign/exponent/mantissa into RESULT
// DONE  | ACK_FX high, held until RST_FSM_FX
module fixed_to_float_norm_v #(
    parameter int FRAC_BITS = 26
) (
    input  logic        CLK,
    input  logic        RST_FX,
    input  logic        RST_FSM_FX,
    input  logic        BEGIN_FSM_FX,
    input  logic [31:0] FIXED,
    output logic        ACK_FX,
    output logic [31:0] RESULT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_NORM  = 3'd2,
        S_PACK  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // 127 bias + 31 (bit position of the leading one) - FRAC_BITS; count is subtracted at pack time
    localparam logic [7:0] EXP_BASE = 8'(158 - FRAC_BITS);

    state_t      r_state;
    state_t      w_next;
    logic        r_sign;
    logic        r_zero;
    logic [31:0] r_mag;
    logic [4:0]  r_count;
    logic [31:0] r_result;

    logic [31:0] w_abs;
    logic [7:0]  w_exp;
    logic [22:0] w_mant;
    logic [7:0]  w_exp_fin;
    logic [22:0] w_mant_fin;
    logic [31:0] w_packed;

    assign w_abs  = FIXED[31] ? (~FIXED + 32'd1) : FIXED;
    assign w_exp  = EXP_BASE - {3'b000, r_count};
    assign w_mant = r_mag[30:8];

`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
    logic        w_round_up;
    logic [23:0] w_mant_inc;

    assign w_round_up = r_mag[7] & ((|r_mag[6:0]) | r_mag[8]);
    assign w_mant_inc = {1'b0, w_mant} + 24'd1;

    always_comb begin
        w_exp_fin  = w_exp;
        w_mant_fin = w_mant;
        if (w_round_up) begin
            if (w_mant_inc[23]) begin
                w_mant_fin = 23'd0;
                w_exp_fin  = w_exp + 8'd1;
            end else begin
                w_mant_fin = w_mant_inc[22:0];
            end
        end
    end
`else
    assign w_exp_fin  = w_exp;
    assign w_mant_fin = w_mant;
`endif

    // zero always packs as +0
    assign w_packed = r_zero ? 32'h0000_0000 : {r_sign, w_exp_fin, w_mant_fin};

    always_ff @(posedge CLK) begin
        if (RST_FX) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (BEGIN_FSM_FX) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((r_mag == 32'd0) || r_mag[31]) begin
                    w_next = S_PACK;
                end else begin
                    w_next = S_NORM;
                end
            end
            S_NORM: begin
                if (r_mag[30]) begin
                    w_next = S_PACK;
                end
            end
            S_PACK:  w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (RST_FSM_FX) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_FX) begin
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_mag    <= 32'd0;
            r_count  <= 5'd0;
            r_result <= 32'd0;
        end else if (!RST_FSM_FX) begin
            case (r_state)
                S_IDLE: begin
                    if (BEGIN_FSM_FX) begin
                        r_sign  <= FIXED[31];
                        r_mag   <= w_abs;
                        r_count <= 5'd0;
                        r_zero  <= 1'b0;
                    end
                end
                S_CHECK: r_zero <= (r_mag == 32'd0);
                S_NORM: begin
                    r_mag   <= {r_mag[30:0], 1'b0};
                    r_count <= r_count + 5'd1;
                end
                S_PACK:  r_result <= w_packed;
                default: ;
            endcase
        end
    end

    assign ACK_FX = (r_state == S_DONE);
    assign RESULT = r_result;

endmodule

// File: tb/tb_fixed_to_float_norm_v.sv
// Scoreboard bench for fixed_to_float_norm_v: stimulus queues expected result and latency,
// a monitor checks them when ACK_FX rises.
module tb_fixed_to_float_norm_v;

    logic        CLK = 1'b0;
    logic        RST_FX = 1'b1;
    logic        RST_FSM_FX = 1'b0;
    logic        BEGIN_FSM_FX = 1'b0;
    logic [31:0] FIXED = 32'd0;
    logic        ACK_FX;
    logic [31:0] RESULT;

    fixed_to_float_norm_v #(.FRAC_BITS(26)) dut (
        .CLK          (CLK),
        .RST_FX       (RST_FX),
        .RST_FSM_FX   (RST_FSM_FX),
        .BEGIN_FSM_FX (BEGIN_FSM_FX),
        .FIXED        (FIXED),
        .ACK_FX       (ACK_FX),
        .RESULT       (RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   e0 = 0;
    logic ack_prev = 1'b0;

`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
    localparam logic [31:0] R_7FFF = 32'h4200_0000;
    localparam logic [31:0] R_1234 = 32'h4091_A2B4;
`else
    localparam logic [31:0] R_7FFF = 32'h41FF_FFFF;
    localparam logic [31:0] R_1234 = 32'h4091_A2B3;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (ACK_FX && !ack_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {31'd0, ACK_FX}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", RESULT, mon_e.res);
                chk("latency", 32'(cyc - e0), 32'(mon_e.lat));
            end
        end
        ack_prev = ACK_FX;
    end

    task automatic conv(input logic [31:0] fx, input logic [31:0] res, input int lat, input bit glitch);
        @(negedge CLK);
        FIXED = fx;
        BEGIN_FSM_FX = 1'b1;
        sb.push_back('{res: res, lat: lat});
        @(negedge CLK);
        e0 = cyc;
        BEGIN_FSM_FX = 1'b0;
        FIXED = ~fx;
        for (int i = 0; i < 40 && !ACK_FX; i++) begin
            if (glitch && i == 3) begin
                BEGIN_FSM_FX = 1'b1;
                FIXED = 32'h7FFF_FFFF;
            end else begin
                BEGIN_FSM_FX = 1'b0;
            end
            @(negedge CLK);
        end
        BEGIN_FSM_FX = 1'b0;
        chk("ack_seen", {31'd0, ACK_FX}, 32'd1);
        if (!ACK_FX) sb.delete();
    endtask

    task automatic release_fsm(input logic [31:0] res);
        FIXED = 32'h1234_5678;
        BEGIN_FSM_FX = 1'b1;
        repeat (3) @(negedge CLK);
        BEGIN_FSM_FX = 1'b0;
        chk("ack_hold", {31'd0, ACK_FX}, 32'd1);
        chk("result_hold", RESULT, res);
        RST_FSM_FX = 1'b1;
        @(negedge CLK);
        RST_FSM_FX = 1'b0;
        chk("ack_clear", {31'd0, ACK_FX}, 32'd0);
        chk("result_kept", RESULT, res);
    endtask

    logic [31:0] v_fx [9] = '{32'h0400_0000, 32'hFA00_0000, 32'h8000_0000, 32'h0000_0000,
                              32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF,
                              32'h1234_5678};
    logic [31:0] v_res [9] = '{32'h3F80_0000, 32'hBFC0_0000, 32'hC200_0000, 32'h0000_0000,
                               32'h3280_0000, R_7FFF, 32'h3340_0000, 32'hB280_0000,
                               R_1234};
    int v_lat [9] = '{7, 7, 2, 2, 33, 3, 32, 33, 5};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        RST_FX = 1'b0;
        chk("reset_result", RESULT, 32'h0);
        chk("reset_ack", {31'd0, ACK_FX}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            conv(v_fx[i], v_res[i], v_lat[i], 1'b0);
            release_fsm(v_res[i]);
        end

        // abort a long normalisation at edge E0+10
        @(negedge CLK);
        FIXED = 32'h0000_0001;
        BEGIN_FSM_FX = 1'b1;
        @(negedge CLK);
        BEGIN_FSM_FX = 1'b0;
        repeat (9) @(negedge CLK);
        RST_FSM_FX = 1'b1;
        @(negedge CLK);
        RST_FSM_FX = 1'b0;
        chk("abort_ack", {31'd0, ACK_FX}, 32'd0);
        chk("abort_result", RESULT, R_1234);
        repeat (40) @(negedge CLK);
        chk("abort_idle_ack", {31'd0, ACK_FX}, 32'd0);
        chk("abort_idle_result", RESULT, R_1234);

        // re-begin with a stray BEGIN during NORM
        conv(32'h0000_0001, 32'h3280_0000, 33, 1'b1);
        release_fsm(32'h3280_0000);

        // system reset while in DONE
        conv(32'hFA00_0000, 32'hBFC0_0000, 7, 1'b0);
        @(negedge CLK);
        RST_FX = 1'b1;
        @(negedge CLK);
        RST_FX = 1'b0;
        chk("rst_done_result", RESULT, 32'h0);
        chk("rst_done_ack", {31'd0, ACK_FX}, 32'd0);
        conv(32'h0400_0000, 32'h3F80_0000, 7, 1'b0);
        release_fsm(32'h3F80_0000);

        // system reset together with FSM reset
        conv(32'h8000_0000, 32'hC200_0000, 2, 1'b0);
        @(negedge CLK);
        RST_FX = 1'b1;
        RST_FSM_FX = 1'b1;
        @(negedge CLK);
        RST_FX = 1'b0;
        RST_FSM_FX = 1'b0;
        chk("rst_both_result", RESULT, 32'h0);
        chk("rst_both_ack", {31'd0, ACK_FX}, 32'd0);
        conv(32'h7FFF_FFFF, R_7FFF, 3, 1'b0);
        release_fsm(R_7FFF);

        repeat (2) @(negedge CLK);
        if (sb.size() != 0) chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
